// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the master and the register-map slave.
//  - axi_resp_e  : xRESP codes (OKAY, EXOKAY, SLVERR, DECERR)
//  - mst_state_e : master transaction FSM states
//  - sat_inc     : saturating increment used by the latency counter
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrAwW,
    StWrB,
    StRdAr,
    StRdR,
    StResp
  } mst_state_e;

  localparam int unsigned CyclesW = 16;
  localparam logic [CyclesW-1:0] CyclesMax = '1;

  function automatic logic [CyclesW-1:0] sat_inc(input logic [CyclesW-1:0] v);
    return (v == CyclesMax) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator.
// A local command (cmd_*) is turned into one complete single-beat AXI4-Lite read or write.
// When the transfer finishes, rsp_valid pulses for one cycle with the slave's response,
// the read data (0 for writes) and the accept-to-response latency (saturating at 16'hFFFF).
// Ports:
//  ACLK, ARESETn                : clock, asynchronous active-low reset
//  cmd_valid/ready/write/addr/wdata/wstrb : command handshake and payload
//  rsp_valid/resp/rdata/cycles  : completion pulse and results (no backpressure)
//  AW*, W*, B*, AR*, R*         : AXI4-Lite master channels, all outputs registered
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // local command
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  // local response
  output logic                rsp_valid,
  output logic [1:0]          rsp_resp,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [15:0]         rsp_cycles,
  // write address
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [2:0]          AWPROT,
  // write data
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  // write response
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP,
  // read address
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [2:0]          ARPROT,
  // read data
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP
);

  localparam int unsigned StrbW = DATA_W / 8;

  mst_state_e          state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]    wstrb_q, wstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [CyclesW-1:0]  rsp_cycles_q, rsp_cycles_d;
  logic [CyclesW-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awaddr_d     = awaddr_q;
    araddr_d     = araddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rsp_valid_d  = 1'b0;
    rsp_resp_d   = rsp_resp_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_cycles_d = rsp_cycles_q;
    // Counts every edge while a transfer is in flight, including the edge entering StResp.
    cnt_d        = sat_inc(cnt_q);

    unique case (state_q)
      StIdle: begin
        cnt_d       = cnt_q;
        // cmd_ready comes up one cycle after reset release, then stays up while idle.
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWrAwW;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = StRdAr;
          end
        end
      end
      StWrAwW: begin
        // AW and W complete independently; each VALID drops after its own handshake.
        if (awvalid_q && AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = StWrB;
        end
      end
      StWrB: begin
        if (BVALID && bready_q) begin
          bready_d     = 1'b0;
          rsp_resp_d   = BRESP;
          rsp_rdata_d  = '0;
          rsp_cycles_d = cnt_d;
          rsp_valid_d  = 1'b1;
          state_d      = StResp;
        end
      end
      StRdAr: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdR;
        end
      end
      StRdR: begin
        if (RVALID && rready_q) begin
          rready_d     = 1'b0;
          rsp_resp_d   = RRESP;
          rsp_rdata_d  = RDATA;
          rsp_cycles_d = cnt_d;
          rsp_valid_d  = 1'b1;
          state_d      = StResp;
        end
      end
      StResp: begin
        cnt_d       = cnt_q;
        cmd_ready_d = 1'b1;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= StIdle;
      cmd_ready_q  <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_resp_q   <= RespOkay;
      rsp_rdata_q  <= '0;
      rsp_cycles_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awaddr_q     <= awaddr_d;
      araddr_q     <= araddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_resp_q   <= rsp_resp_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_cycles_q <= rsp_cycles_d;
      cnt_q        <= cnt_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_resp   = rsp_resp_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_cycles = rsp_cycles_q;
  assign AWVALID    = awvalid_q;
  assign AWADDR     = awaddr_q;
  assign AWPROT     = 3'b000;
  assign WVALID     = wvalid_q;
  assign WDATA      = wdata_q;
  assign WSTRB      = wstrb_q;
  assign BREADY     = bready_q;
  assign ARVALID    = arvalid_q;
  assign ARADDR     = araddr_q;
  assign ARPROT     = 3'b000;
  assign RREADY     = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: random and directed commands, a delay-programmable stub slave
// with its own memory, a reference model for expected responses, and a scoreboard monitor.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;
  logic [15:0] rsp_cycles;
  logic        AWVALID, AWREADY = 1'b0, WVALID, WREADY = 1'b0;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        BVALID = 1'b0, BREADY, ARVALID, ARREADY = 1'b0, RVALID = 1'b0, RREADY;
  logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;
  logic [31:0] RDATA = '0;

  always #5 ACLK = ~ACLK;

  axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
    .rsp_cycles(rsp_cycles),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_d, w_d, b_d, ar_d, r_d;
  } txn_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [15:0] cycles;
  } exp_t;

  txn_t        sl_q[$];
  exp_t        exp_q[$];
  logic [31:0] model_mem[16];
  logic [31:0] sl_mem[16];
  int          n_chk = 0, n_err = 0;
  int          cyc = 0, last_acc_cyc = 0, last_rsp_cyc = 0, outstanding = 0;

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: 15 word registers at 0x00..0x38, 0x28 read-only, everything else DECERR.
  function automatic logic [1:0] model_decode(input logic [31:0] a, input logic wr);
    if (a[1:0] != 2'b00 || a >= 32'h3C) return RespDecerr;
    if (wr && a == 32'h28) return RespSlverr;
    return RespOkay;
  endfunction

  // Stub slave decode, written from the register index rather than the byte address.
  function automatic logic [1:0] slave_resp(input logic [31:0] a, input logic wr);
    logic [1:0] r;
    r = RespOkay;
    if (a[31:6] != '0 || a[1:0] != 2'b00 || a[5:2] == 4'd15) r = RespDecerr;
    else if (wr && a[5:2] == 4'd10) r = RespSlverr;
    return r;
  endfunction

  function automatic txn_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int d1, input int d2, input int d3);
    txn_t t;
    t.write = wr; t.addr = a; t.wdata = d; t.wstrb = s;
    t.aw_d = wr ? d1 : 0; t.w_d = wr ? d2 : 0; t.b_d = wr ? d3 : 0;
    t.ar_d = wr ? 0 : d1; t.r_d = wr ? 0 : d2;
    return t;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input txn_t t, input bit hold_after);
    exp_t e;
    int   lat;
    bit   got;
    if (t.write) begin
      e.resp  = model_decode(t.addr, 1'b1);
      e.rdata = '0;
      if (e.resp == RespOkay)
        for (int b = 0; b < 4; b++)
          if (t.wstrb[b]) model_mem[t.addr[5:2]][8*b +: 8] = t.wdata[8*b +: 8];
      lat = 2 + ((t.aw_d > t.w_d) ? t.aw_d : t.w_d) + t.b_d;
    end else begin
      e.resp  = model_decode(t.addr, 1'b0);
      e.rdata = (e.resp == RespOkay) ? model_mem[t.addr[5:2]] : 32'h0;
      lat = 2 + t.ar_d + t.r_d;
    end
    e.cycles = (lat > 65535) ? 16'hFFFF : 16'(lat);
    sl_q.push_back(t);
    exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_write = t.write; cmd_addr = t.addr;
    cmd_wdata = t.wdata; cmd_wstrb = t.wstrb;
    got = 1'b0;
    for (int i = 0; i < 80000; i++) begin
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge ACLK);
    end
    if (!got) begin
      chk("accept_timeout", 64'(got), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    chk("two_in_flight", 64'(outstanding), 64'd0);
    outstanding++;
    last_acc_cyc = cyc;
    @(negedge ACLK);
    chk("cmd_ready_busy", cmd_ready, 1'b0);
    if (t.write) chk("aw_w_valid_after_accept", {AWVALID, WVALID}, 2'b11);
    else         chk("arvalid_after_accept", ARVALID, 1'b1);
    if (!hold_after) cmd_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge ACLK);
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic slave_wr(input txn_t t);
    int         mx;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [1:0]  r;
    mx = (t.aw_d > t.w_d) ? t.aw_d : t.w_d;
    a = '0; d = '0; s = '0;
    for (int i = 0; i <= mx; i++) begin
      if (i > 0) @(negedge ACLK);
      chk("bready_early", BREADY, 1'b0);
      if (i <= t.aw_d) begin
        chk("awvalid_hold", AWVALID, 1'b1);
        chk("awaddr_stable", AWADDR, t.addr);
      end else chk("awvalid_drop", AWVALID, 1'b0);
      if (i <= t.w_d) begin
        chk("wvalid_hold", WVALID, 1'b1);
        chk("wdata_stable", WDATA, t.wdata);
        chk("wstrb_stable", WSTRB, t.wstrb);
      end else chk("wvalid_drop", WVALID, 1'b0);
      AWREADY = (i == t.aw_d);
      WREADY  = (i == t.w_d);
      if (i == t.aw_d) a = AWADDR;
      if (i == t.w_d) begin
        d = WDATA;
        s = WSTRB;
      end
    end
    @(negedge ACLK);
    AWREADY = 1'b0; WREADY = 1'b0;
    chk("aw_w_valid_drop", {AWVALID, WVALID}, 2'b00);
    chk("bready_after_aw_w", BREADY, 1'b1);
    r = slave_resp(a, 1'b1);
    if (r == RespOkay)
      for (int b = 0; b < 4; b++) if (s[b]) sl_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
    for (int j = 0; j < t.b_d; j++) begin
      @(negedge ACLK);
      if (!ARESETn) break;
    end
    if (!ARESETn) return;
    BRESP = r; BVALID = 1'b1;
    chk("bready_at_bvalid", BREADY, 1'b1);
    @(negedge ACLK);
    BVALID = 1'b0;
  endtask

  task automatic slave_rd(input txn_t t);
    logic [1:0] r;
    for (int i = 0; i <= t.ar_d; i++) begin
      if (i > 0) @(negedge ACLK);
      chk("arvalid_hold", ARVALID, 1'b1);
      chk("araddr_stable", ARADDR, t.addr);
      chk("rready_early", RREADY, 1'b0);
      ARREADY = (i == t.ar_d);
    end
    @(negedge ACLK);
    ARREADY = 1'b0;
    chk("arvalid_drop", ARVALID, 1'b0);
    for (int j = 0; j < t.r_d; j++) @(negedge ACLK);
    r = slave_resp(t.addr, 1'b0);
    RRESP = r;
    RDATA = (r == RespOkay) ? sl_mem[t.addr[5:2]] : 32'h0;
    RVALID = 1'b1;
    chk("rready_at_rvalid", RREADY, 1'b1);
    @(negedge ACLK);
    RVALID = 1'b0;
  endtask

  // Stub slave: picks up each transaction when its first VALID appears.
  initial forever begin
    txn_t t;
    @(negedge ACLK);
    if (ARESETn && (AWVALID || WVALID || ARVALID)) begin
      if (sl_q.size() == 0) begin
        chk("unexpected_valid", {AWVALID, WVALID, ARVALID}, 3'b000);
      end else begin
        t = sl_q.pop_front();
        chk("channel_type", (AWVALID | WVALID), t.write);
        if (t.write) slave_wr(t);
        else         slave_rd(t);
      end
    end
  end

  // Scoreboard monitor.
  initial forever begin
    exp_t e;
    @(negedge ACLK);
    if (ARESETn && rsp_valid) begin
      last_rsp_cyc = cyc;
      outstanding--;
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp_valid", rsp_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_resp", rsp_resp, e.resp);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_cycles", rsp_cycles, e.cycles);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = '0;
      sl_mem[i]    = '0;
    end
    model_mem[10] = 32'h7e8155aa;
    sl_mem[10]    = 32'h7e8155aa;

    #1 ARESETn = 1'b0;
    #1;
    chk("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 6'b0);
    chk("rst_addrs", {AWADDR, ARADDR}, 64'h0);
    chk("rst_wdata_wstrb", {WDATA, WSTRB}, 36'h0);
    chk("rst_rsp", {rsp_resp, rsp_rdata, rsp_cycles}, 50'h0);
    chk("prot", {AWPROT, ARPROT}, 6'b0);
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("cmd_ready_after_reset", cmd_ready, 1'b1);

    // Write 0xA5 to byte 0 of 0x00, read it back.
    issue(mk(1'b1, 32'h00, 32'h000000A5, 4'b0001, 0, 0, 0), 1'b0);
    drain(100);
    chk("slave_led_byte", sl_mem[0][7:0], 8'hA5);
    issue(mk(1'b0, 32'h00, 32'h0, 4'h0, 0, 0, 0), 1'b0);
    drain(100);

    // AWREADY right away, WREADY four cycles later.
    issue(mk(1'b1, 32'h08, 32'hDEADBEEF, 4'b1111, 0, 4, 1), 1'b0);
    drain(100);

    // Read-only constant and an unmapped address.
    issue(mk(1'b0, 32'h28, 32'h0, 4'h0, 1, 2, 0), 1'b0);
    issue(mk(1'b0, 32'h3C, 32'h0, 4'h0, 0, 0, 0), 1'b0);
    drain(100);

    // Back-to-back with cmd_valid held: second accept the cycle after rsp_valid.
    issue(mk(1'b1, 32'h0C, 32'h12345678, 4'b1010, 1, 0, 2), 1'b1);
    issue(mk(1'b0, 32'h0C, 32'h0, 4'h0, 0, 1, 0), 1'b0);
    chk("b2b_accept_cycle", 64'(last_acc_cyc), 64'(last_rsp_cyc + 1));
    drain(100);

    // Random traffic, with occasional back-to-back issue.
    for (int n = 0; n < 40; n++) begin
      txn_t t;
      t = mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 16) * 4), $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3));
      issue(t, (n < 39) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    drain(1000);

    // Reset while waiting for BVALID: transfer abandoned, no response.
    issue(mk(1'b1, 32'h04, 32'hCAFEF00D, 4'b1111, 0, 1, 40), 1'b0);
    for (int i = 0; i < 50 && !BREADY; i++) @(negedge ACLK);
    chk("reached_wr_b", BREADY, 1'b1);
    @(negedge ACLK);
    #1 ARESETn = 1'b0;
    #1;
    chk("mid_rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 6'b0);
    chk("mid_rst_outputs", {AWADDR, WDATA, rsp_cycles}, 80'h0);
    exp_q.delete();
    outstanding = 0;
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("cmd_ready_after_mid_reset", cmd_ready, 1'b1);
    issue(mk(1'b0, 32'h04, 32'h0, 4'h0, 2, 1, 0), 1'b0);
    issue(mk(1'b1, 32'h10, 32'h0BADF00D, 4'b1100, 2, 0, 0), 1'b0);
    drain(200);

    // Very slow BVALID: latency must saturate.
    issue(mk(1'b1, 32'h14, 32'h55AA55AA, 4'b1111, 0, 0, 70000), 1'b0);
    drain(75000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
